alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NUMBITS, default 16, operand/result width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_opcode / req0_a / req0_b  input  3 / NUMBITS / NUMBITS  requester 0 opcode and operands.
REQ-007 req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same directions/widths, requester 1.
REQ-008 resp_valid  output  1  response holds a completed result.
REQ-009 resp_ready  input  1  consumer takes response this cycle.
REQ-010 resp_id  output  1  requester the response belongs to.
REQ-011 resp_result  output  NUMBITS  ALU result.
REQ-012 resp_carry / resp_overflow / resp_zero  output  1 each  ALU carryout/overflow/zero flags.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, EXEC, CAPT, RESP; transitions IDLE->EXEC on accept, EXEC->CAPT unconditionally, CAPT->RESP unconditionally, RESP->IDLE on resp_ready.
REQ-015 reqN_ready combinational: high only in IDLE, only for the granted requester, only while its valid is high; at most one ready high per cycle.
REQ-016 Accept = reqN_valid & reqN_ready at a rising edge; opcode, a, b and id latched at that edge.
REQ-017 Grant: one valid -> that requester; both valid -> requester != last_grant; last_grant updated on each accept.
REQ-018 EXEC: latched opcode/a/b drive the internal ALU, held stable through EXEC and CAPT.
REQ-019 CAPT: ALU registered outputs loaded into resp_result and flags at the end of CAPT.
REQ-020 resp_valid rises at the 3rd rising edge after the accept edge (accept, EXEC end, CAPT end) and stays high until resp_ready is sampled high.
REQ-021 resp_* fields stable while resp_valid high and resp_ready low; resp_valid low in all other states.
REQ-022 resp_ready ignored outside RESP; RESP with resp_ready high returns to IDLE, new accept possible next cycle (min 4 cycles per operation).
REQ-023 No accept while busy; requesters hold valid and operands until ready.
REQ-024 Opcode passed unmodified: 000 uadd, 001 sadd, 010 usub, 011 ssub, 100 and, 101 or, 110 xor, 111 A<<1; result width NUMBITS, flags as produced by the ALU.
REQ-025 valid dropped before grant: no accept and no state change.

Reset
REQ-026 reset low, at any state: asynchronously state=IDLE, resp_valid=0, resp_id=0, resp_result=0, resp_carry=0, resp_overflow=0, resp_zero=0, busy=0, both readys=0, last_grant=1 (requester 0 wins first contention).
REQ-027 Reset mid-operation discards the in-flight operation; no response after release.
REQ-028 Internal ALU reset driven by the inverse of reset.

Structure
REQ-029 Shared package alu_pkg: opcode constants (REQ-024), FSM state encoding, NUMBITS default.
REQ-030 Exactly one sub-module: myalu (NUMBITS, clk, opcode, A, B, result, carryout, overflow, zero), one-cycle registered latency.
REQ-031 Arbitration, FSM and response registers in alu_arbiter; no other sub-modules.

Verification
REQ-032 req0 uadd 0x0003+0x0004, resp_ready=1 -> resp_id=0, result 0x0007, carry 0, zero 0, resp_valid 3 edges after accept.
REQ-033 req0 and req1 valid at reset release -> req0 served first, then req1; resp_id 0 then 1; never both readys high.
REQ-034 req1 uadd 0xFFFF+0x0001 -> result 0x0000, carry 1, zero 1; req1 sadd 0x7FFF+0x0001 -> result 0x8000, overflow 1.
REQ-035 resp_ready held low 5 cycles in RESP with both requesters valid -> resp fields stable, busy 1, no ready pulses; resp_ready=1 -> IDLE, next grant to other requester.
REQ-036 reset low during CAPT -> resp_valid, busy 0 without clock edge; after release no stale response, req0 wins first contention.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcode encodings, FSM states
// and the default operand width.
package alu_pkg;

   localparam int NUMBITS_DEF = 16;

   localparam logic [2:0] OP_UADD = 3'b000;
   localparam logic [2:0] OP_SADD = 3'b001;
   localparam logic [2:0] OP_USUB = 3'b010;
   localparam logic [2:0] OP_SSUB = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_SHL  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/myalu.sv
// Registered ALU: result and flags appear one clock after opcode/operands.
// Carry on subtraction is the borrow out; unsigned ops report overflow as carry.
module myalu
   import alu_pkg::*;
#(
   parameter int NUMBITS = NUMBITS_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         opcode,
   input  logic [NUMBITS-1:0] A,
   input  logic [NUMBITS-1:0] B,
   output logic [NUMBITS-1:0] result,
   output logic               carryout,
   output logic               overflow,
   output logic               zero
);

   logic [NUMBITS:0]   sum;
   logic [NUMBITS:0]   dif;
   logic [NUMBITS-1:0] r_n;
   logic               c_n;
   logic               v_n;

   always_comb begin
      sum = {1'b0, A} + {1'b0, B};
      dif = {1'b0, A} - {1'b0, B};
      r_n = '0;
      c_n = 1'b0;
      v_n = 1'b0;
      case (opcode)
         OP_UADD: begin
            r_n = sum[NUMBITS-1:0];
            c_n = sum[NUMBITS];
            v_n = sum[NUMBITS];
         end
         OP_SADD: begin
            r_n = sum[NUMBITS-1:0];
            c_n = sum[NUMBITS];
            v_n = (A[NUMBITS-1] == B[NUMBITS-1]) && (r_n[NUMBITS-1] != A[NUMBITS-1]);
         end
         OP_USUB: begin
            r_n = dif[NUMBITS-1:0];
            c_n = dif[NUMBITS];
            v_n = dif[NUMBITS];
         end
         OP_SSUB: begin
            r_n = dif[NUMBITS-1:0];
            c_n = dif[NUMBITS];
            v_n = (A[NUMBITS-1] != B[NUMBITS-1]) && (r_n[NUMBITS-1] != A[NUMBITS-1]);
         end
         OP_AND: r_n = A & B;
         OP_OR:  r_n = A | B;
         OP_XOR: r_n = A ^ B;
         default: begin
            r_n = {A[NUMBITS-2:0], 1'b0};
            c_n = A[NUMBITS-1];
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result   <= '0;
         carryout <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         result   <= r_n;
         carryout <= c_n;
         overflow <= v_n;
         zero     <= (r_n == '0);
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared registered ALU: round-robin grant,
// operand latch, four-state sequencer and a held response register.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUMBITS = NUMBITS_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [2:0]         req0_opcode,
   input  logic [NUMBITS-1:0] req0_a,
   input  logic [NUMBITS-1:0] req0_b,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [2:0]         req1_opcode,
   input  logic [NUMBITS-1:0] req1_a,
   input  logic [NUMBITS-1:0] req1_b,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic               resp_id,
   output logic [NUMBITS-1:0] resp_result,
   output logic               resp_carry,
   output logic               resp_overflow,
   output logic               resp_zero,
   output logic               busy
);

   state_t             state;
   logic               last_grant;
   logic [2:0]         op_q;
   logic [NUMBITS-1:0] a_q;
   logic [NUMBITS-1:0] b_q;
   logic               id_q;
   logic               idle;
   logic               gnt1;
   logic               alu_rst;
   logic [NUMBITS-1:0] alu_result;
   logic               alu_carry;
   logic               alu_ovf;
   logic               alu_zero;

   // Readys are held low while reset is asserted even though state is IDLE.
   assign idle       = (state == IDLE) && reset;
   assign gnt1       = req1_valid && (!req0_valid || !last_grant);
   assign req0_ready = idle && req0_valid && !gnt1;
   assign req1_ready = idle && gnt1;
   assign alu_rst    = ~reset;

   myalu #(.NUMBITS(NUMBITS)) u_alu (
      .clk      (clk),
      .reset    (alu_rst),
      .opcode   (op_q),
      .A        (a_q),
      .B        (b_q),
      .result   (alu_result),
      .carryout (alu_carry),
      .overflow (alu_ovf),
      .zero     (alu_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         last_grant    <= 1'b1;
         op_q          <= OP_UADD;
         a_q           <= '0;
         b_q           <= '0;
         id_q          <= 1'b0;
         resp_valid    <= 1'b0;
         resp_id       <= 1'b0;
         resp_result   <= '0;
         resp_carry    <= 1'b0;
         resp_overflow <= 1'b0;
         resp_zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready || req1_ready) begin
                  state      <= EXEC;
                  busy       <= 1'b1;
                  last_grant <= req1_ready;
                  id_q       <= req1_ready;
                  op_q       <= req1_ready ? req1_opcode : req0_opcode;
                  a_q        <= req1_ready ? req1_a : req0_a;
                  b_q        <= req1_ready ? req1_b : req0_b;
               end
            end
            EXEC: state <= CAPT;
            CAPT: begin
               state         <= RESP;
               resp_valid    <= 1'b1;
               resp_id       <= id_q;
               resp_result   <= alu_result;
               resp_carry    <= alu_carry;
               resp_overflow <= alu_ovf;
               resp_zero     <= alu_zero;
            end
            default: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  resp_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, contention/stall/reset
// sequences and random ops, all checked through a response scoreboard.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [2:0]   req0_opcode = '0, req1_opcode = '0;
   logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         resp_valid, resp_ready = 1'b1, resp_id;
   logic [N-1:0] resp_result;
   logic         resp_carry, resp_overflow, resp_zero, busy;

   always #5 clk = ~clk;

   alu_arbiter #(.NUMBITS(N)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_carry(resp_carry),
      .resp_overflow(resp_overflow), .resp_zero(resp_zero), .busy(busy)
   );

   typedef struct {
      logic         id;
      logic [2:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] r;
      logic         c;
      logic         ov;
      logic         z;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[10];
   vec_t mon_e;
   int   total = 0;
   int   bad = 0;
   bit   both_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic expired(input string name);
      total++;
      bad++;
      $display("FAIL %s: got no DUT event required event within bound", name);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input logic id, input logic val, input logic [2:0] op,
                          input logic [N-1:0] a, input logic [N-1:0] b);
      if (id) begin
         req1_valid = val; req1_opcode = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = val; req0_opcode = op; req0_a = a; req0_b = b;
      end
   endtask

   function automatic logic rdy(input logic id);
      return id ? req1_ready : req0_ready;
   endfunction

   function automatic vec_t model(input logic id, input logic [2:0] op,
                                  input logic [N-1:0] a, input logic [N-1:0] b);
      vec_t   e;
      longint ua, ub, sa, sb2, s;
      ua = a; ub = b; sa = $signed(a); sb2 = $signed(b);
      e.id = id; e.op = op; e.a = a; e.b = b; e.c = 1'b0; e.ov = 1'b0;
      s = 0;
      case (op)
         3'd0: begin s = ua + ub; e.c = (s > 65535); e.ov = e.c; end
         3'd1: begin s = sa + sb2; e.c = ((ua + ub) > 65535); e.ov = (s > 32767) || (s < -32768); end
         3'd2: begin s = ua - ub; e.c = (ua < ub); e.ov = e.c; end
         3'd3: begin s = sa - sb2; e.c = (ua < ub); e.ov = (s > 32767) || (s < -32768); end
         3'd4: s = longint'(a & b);
         3'd5: s = longint'(a | b);
         3'd6: s = longint'(a ^ b);
         default: begin s = ua * 2; e.c = a[N-1]; end
      endcase
      e.r = s[N-1:0];
      e.z = (e.r == '0);
      return e;
   endfunction

   task automatic wait_ready(input logic id, output bit ok);
      int n = 0;
      while (!rdy(id) && n < 20) begin step(); #1; n++; end
      ok = rdy(id);
      if (!ok) expired("ready_wait");
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin step(); n++; end
      if (busy) expired("idle_wait");
   endtask

   task automatic run_op(input vec_t e);
      bit ok;
      int n;
      set_req(e.id, 1'b1, e.op, e.a, e.b);
      #1;
      wait_ready(e.id, ok);
      if (!ok) begin
         set_req(e.id, 1'b0, '0, '0, '0);
         return;
      end
      sb.push_back(e);
      step();
      set_req(e.id, 1'b0, '0, '0, '0);
      n = 0;
      while (!resp_valid && n < 10) begin step(); n++; end
      chk("resp_latency", n, 2);
      wait_idle();
   endtask

   // Response monitor: a handshake seen here completes at the next rising edge.
   initial forever begin
      @(negedge clk);
      #3;
      if (req0_ready && req1_ready) both_ready = 1'b1;
      if (reset && resp_valid && resp_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got id=%0d result=%0h required no response", resp_id, resp_result);
         end else begin
            mon_e = sb.pop_front();
            chk("resp_id", resp_id, mon_e.id);
            chk("resp_result", resp_result, mon_e.r);
            chk("resp_carry", resp_carry, mon_e.c);
            chk("resp_overflow", resp_overflow, mon_e.ov);
            chk("resp_zero", resp_zero, mon_e.z);
         end
      end
   end

   initial begin
      vec_t e0, e1, snap;
      bit   ok, stable, no_rdy, busy_ok;

      tbl[0] = '{1'b0, OP_UADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, OP_UADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1};
      tbl[2] = '{1'b1, OP_SADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b0, OP_USUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, OP_SSUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, OP_SSUB, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b1, OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, OP_OR,   16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b1, OP_XOR,  16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{1'b0, OP_SHL,  16'h8001, 16'h1234, 16'h0002, 1'b1, 1'b0, 1'b0};

      // Reset values, with both requesters already asking.
      e0 = '{1'b0, OP_UADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0};
      e1 = '{1'b1, OP_XOR,  16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 1'b0};
      set_req(1'b0, 1'b1, e0.op, e0.a, e0.b);
      set_req(1'b1, 1'b1, e1.op, e1.a, e1.b);
      #2;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_result", resp_result, 0);
      chk("rst_flags", {resp_carry, resp_overflow, resp_zero}, 0);

      // Contention at reset release: req0 first, then req1.
      step(); step();
      reset = 1'b1;
      #1;
      chk("first_grant_req0", req0_ready, 1);
      chk("first_grant_req1", req1_ready, 0);
      sb.push_back(e0);
      step();
      set_req(1'b0, 1'b0, '0, '0, '0);
      wait_ready(1'b1, ok);
      if (ok) begin
         sb.push_back(e1);
         step();
      end
      set_req(1'b1, 1'b0, '0, '0, '0);
      wait_idle();

      foreach (tbl[i]) run_op(tbl[i]);

      // Held response with both requesters waiting.
      resp_ready = 1'b0;
      e1 = '{1'b1, OP_OR, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0};
      set_req(1'b1, 1'b1, e1.op, e1.a, e1.b);
      #1;
      wait_ready(1'b1, ok);
      if (ok) begin
         sb.push_back(e1);
         step();
      end
      set_req(1'b1, 1'b0, '0, '0, '0);
      begin
         int n = 0;
         while (!resp_valid && n < 10) begin step(); n++; end
         if (!resp_valid) expired("stall_resp_wait");
      end
      e0 = model(1'b0, OP_USUB, 16'h0100, 16'h0001);
      e1 = model(1'b1, OP_SHL, 16'h4321, 16'h0000);
      set_req(1'b0, 1'b1, e0.op, e0.a, e0.b);
      set_req(1'b1, 1'b1, e1.op, e1.a, e1.b);
      snap.id = resp_id; snap.r = resp_result;
      snap.c = resp_carry; snap.ov = resp_overflow; snap.z = resp_zero;
      stable = 1'b1; no_rdy = 1'b1; busy_ok = 1'b1;
      repeat (5) begin
         step(); #1;
         if (!resp_valid || resp_id !== snap.id || resp_result !== snap.r ||
             resp_carry !== snap.c || resp_overflow !== snap.ov || resp_zero !== snap.z)
            stable = 1'b0;
         if (req0_ready || req1_ready) no_rdy = 1'b0;
         if (!busy) busy_ok = 1'b0;
      end
      chk("stall_resp_stable", stable, 1);
      chk("stall_no_ready", no_rdy, 1);
      chk("stall_busy", busy_ok, 1);
      resp_ready = 1'b1;
      step(); #1;
      chk("after_stall_req0", req0_ready, 1);
      chk("after_stall_req1", req1_ready, 0);
      sb.push_back(e0);
      step();
      set_req(1'b0, 1'b0, '0, '0, '0);
      wait_ready(1'b1, ok);
      if (ok) begin
         sb.push_back(e1);
         step();
      end
      set_req(1'b1, 1'b0, '0, '0, '0);
      wait_idle();

      // Reset during CAPT: req0 served last, so only reset can hand req0 the next contention.
      set_req(1'b0, 1'b1, OP_UADD, 16'h0005, 16'h0006);
      #1;
      wait_ready(1'b0, ok);
      step();
      set_req(1'b0, 1'b0, '0, '0, '0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("capt_rst_resp_valid", resp_valid, 0);
      chk("capt_rst_busy", busy, 0);
      e0 = model(1'b0, OP_AND, 16'hFF00, 16'h0FF0);
      e1 = model(1'b1, OP_SADD, 16'h8000, 16'hFFFF);
      set_req(1'b0, 1'b1, e0.op, e0.a, e0.b);
      set_req(1'b1, 1'b1, e1.op, e1.a, e1.b);
      step(); step();
      reset = 1'b1;
      #1;
      chk("post_rst_grant_req0", req0_ready, 1);
      chk("post_rst_grant_req1", req1_ready, 0);
      sb.push_back(e0);
      step();
      set_req(1'b0, 1'b0, '0, '0, '0);
      wait_ready(1'b1, ok);
      if (ok) begin
         sb.push_back(e1);
         step();
      end
      set_req(1'b1, 1'b0, '0, '0, '0);
      wait_idle();

      for (int unsigned k = 0; k < 16; k++) begin
         logic [N-1:0] ra, rb;
         ra = N'($urandom);
         rb = N'($urandom);
         run_op(model(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), ra, rb));
      end

      repeat (3) step();
      chk("scoreboard_empty", sb.size(), 0);
      chk("never_both_ready", both_ready, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
